// File: rtl/vga_sincronismo_pkg.sv
// Shared VGA timing constants, board-cell geometry and small decode helpers
// used by the raster generator and the drawing blocks downstream of it.
package pacote_vga;

  localparam int COORD_W = 10;

  localparam int DIV_PIXEL_PAD = 2;
  localparam int H_ATIVO_PAD   = 640;
  localparam int H_FP_PAD      = 16;
  localparam int H_SYNC_PAD    = 96;
  localparam int H_BP_PAD      = 48;
  localparam int V_ATIVO_PAD   = 480;
  localparam int V_FP_PAD      = 10;
  localparam int V_SYNC_PAD    = 2;
  localparam int V_BP_PAD      = 33;

  localparam int H_TOTAL = H_ATIVO_PAD + H_FP_PAD + H_SYNC_PAD + H_BP_PAD;
  localparam int V_TOTAL = V_ATIVO_PAD + V_FP_PAD + V_SYNC_PAD + V_BP_PAD;

  localparam int CELULA_L = 54;
  localparam int CELULA_A = 49;

  localparam logic [COORD_W-1:0] ORIGEM_X [10] = '{
    10'd50,  10'd104, 10'd158, 10'd212, 10'd266,
    10'd320, 10'd374, 10'd428, 10'd482, 10'd536
  };
  localparam logic [COORD_W-1:0] ORIGEM_Y [9] = '{
    10'd15,  10'd64,  10'd113, 10'd162, 10'd211,
    10'd260, 10'd309, 10'd358, 10'd407
  };

  typedef struct packed {
    logic area;
    logic hsync;
    logic vsync;
  } sinc_t;

  function automatic logic em_faixa(input logic [COORD_W-1:0] v,
                                    input logic [COORD_W-1:0] lo,
                                    input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sincronismo_if.sv
// Raster bundle seen by the drawing blocks and the monitor sync pins.
interface vga_sincronismo_if;
  import pacote_vga::*;

  logic               pix_en;
  logic [COORD_W-1:0] coluna;
  logic [COORD_W-1:0] linha;
  logic               areaAtiva;
  logic               hsync;
  logic               vsync;
  logic               fim_quadro;

  modport master (
    output pix_en, coluna, linha, areaAtiva, hsync, vsync, fim_quadro
  );

  modport slave (
    input pix_en, coluna, linha, areaAtiva, hsync, vsync, fim_quadro
  );

endinterface

// File: rtl/vga_sincronismo_contador.sv
// Modulo-N counter with enable; o_wrap flags the enabled step from N-1 to 0.
module vga_contador #(
  parameter int N = 2,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  localparam logic [W-1:0] ULT = W'(N - 1);
  localparam logic [W-1:0] UM  = W'(1);

  logic [W-1:0] r_count;
  logic [W-1:0] w_prox;
  logic         w_wrap;

  // next count and terminal-count detection
  always_comb begin
    w_prox = r_count;
    w_wrap = 1'b0;
    if (i_en) begin
      if (r_count == ULT) begin
        w_prox = {W{1'b0}};
        w_wrap = 1'b1;
      end else begin
        w_prox = r_count + UM;
        w_wrap = 1'b0;
      end
    end else begin
      w_prox = r_count;
      w_wrap = 1'b0;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {W{1'b0}};
    end else begin
      r_count <= w_prox;
    end
  end

  assign o_count = r_count;
  assign o_wrap  = w_wrap;

endmodule

// File: rtl/vga_sincronismo.sv
// VGA raster timing generator: pixel-rate divider, column/line counters and
// sync/active-area flags registered so they describe the current pixel.
module vga_sincronismo
  import pacote_vga::*;
#(
  parameter int DIV_PIXEL = DIV_PIXEL_PAD,
  parameter int H_ATIVO   = H_ATIVO_PAD,
  parameter int H_FP      = H_FP_PAD,
  parameter int H_SYNC    = H_SYNC_PAD,
  parameter int H_BP      = H_BP_PAD,
  parameter int V_ATIVO   = V_ATIVO_PAD,
  parameter int V_FP      = V_FP_PAD,
  parameter int V_SYNC    = V_SYNC_PAD,
  parameter int V_BP      = V_BP_PAD
) (
  input  logic clk,
  input  logic rst,
  vga_sincronismo_if.master vga
);

  localparam int H_TOT = H_ATIVO + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ATIVO + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = 3;

  localparam logic [DIV_W-1:0]   DIV_ULT = DIV_W'(DIV_PIXEL - 1);
  localparam logic [DIV_W-1:0]   DIV_UM  = DIV_W'(1);
  localparam logic [COORD_W-1:0] C_UM    = COORD_W'(1);
  localparam logic [COORD_W-1:0] H_VIS   = COORD_W'(H_ATIVO);
  localparam logic [COORD_W-1:0] HS_INI  = COORD_W'(H_ATIVO + H_FP);
  localparam logic [COORD_W-1:0] HS_FIM  = COORD_W'(H_ATIVO + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] V_VIS   = COORD_W'(V_ATIVO);
  localparam logic [COORD_W-1:0] VS_INI  = COORD_W'(V_ATIVO + V_FP);
  localparam logic [COORD_W-1:0] VS_FIM  = COORD_W'(V_ATIVO + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0]   w_div;
  logic               w_div_wrap;
  logic [COORD_W-1:0] w_col;
  logic               w_h_wrap;
  logic [COORD_W-1:0] w_lin;
  logic               w_v_wrap;

  logic [COORD_W-1:0] w_col_prox;
  logic [COORD_W-1:0] w_lin_prox;
  logic               w_pix_prox;
  sinc_t              w_sinc_prox;

  logic r_pix_en;
  logic r_fim;
  logic r_area;
  logic r_hsync;
  logic r_vsync;

  vga_contador #(.N(DIV_PIXEL), .W(DIV_W)) u_div (
    .clk    (clk),
    .rst    (rst),
    .i_en   (1'b1),
    .o_count(w_div),
    .o_wrap (w_div_wrap)
  );

  vga_contador #(.N(H_TOT), .W(COORD_W)) u_horiz (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_pix_en),
    .o_count(w_col),
    .o_wrap (w_h_wrap)
  );

  vga_contador #(.N(V_TOT), .W(COORD_W)) u_vert (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_h_wrap),
    .o_count(w_lin),
    .o_wrap (w_v_wrap)
  );

  // Coordinates after the pending tick; only consumed while r_pix_en is high,
  // so the registered flags always line up with the counters they follow.
  always_comb begin
    w_col_prox = w_col;
    w_lin_prox = w_lin;
    w_pix_prox = 1'b0;
    if (w_h_wrap) begin
      w_col_prox = {COORD_W{1'b0}};
      if (w_v_wrap) begin
        w_lin_prox = {COORD_W{1'b0}};
      end else begin
        w_lin_prox = w_lin + C_UM;
      end
    end else begin
      w_col_prox = w_col + C_UM;
      w_lin_prox = w_lin;
    end
    if (w_div_wrap) begin
      w_pix_prox = (DIV_ULT == {DIV_W{1'b0}});
    end else begin
      w_pix_prox = ((w_div + DIV_UM) == DIV_ULT);
    end
    w_sinc_prox.area  = (w_col_prox < H_VIS) && (w_lin_prox < V_VIS);
    w_sinc_prox.hsync = !em_faixa(w_col_prox, HS_INI, HS_FIM);
    w_sinc_prox.vsync = !em_faixa(w_lin_prox, VS_INI, VS_FIM);
  end

  // pixel strobe, frame pulse and per-pixel flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_en <= 1'b0;
      r_fim    <= 1'b0;
      r_area   <= 1'b0;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
    end else begin
      r_pix_en <= w_pix_prox;
      r_fim    <= w_v_wrap;
      if (r_pix_en) begin
        r_area  <= w_sinc_prox.area;
        r_hsync <= w_sinc_prox.hsync;
        r_vsync <= w_sinc_prox.vsync;
      end else begin
        r_area  <= r_area;
        r_hsync <= r_hsync;
        r_vsync <= r_vsync;
      end
    end
  end

  assign vga.pix_en     = r_pix_en;
  assign vga.coluna     = w_col;
  assign vga.linha      = w_lin;
  assign vga.areaAtiva  = r_area;
  assign vga.hsync      = r_hsync;
  assign vga.vsync      = r_vsync;
  assign vga.fim_quadro = r_fim;

endmodule

// File: tb/tb_vga_sincronismo.sv
// Bench for vga_sincronismo: three shrunken-timing builds (DIV 2, 1, 3) checked
// every cycle against a position-from-elapsed-ticks reference model.
module tb_vga_sincronismo;
  import pacote_vga::*;

  localparam int HA = 16, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int DIVS [3] = '{2, 1, 3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_sincronismo_if if_a ();
  vga_sincronismo_if if_b ();
  vga_sincronismo_if if_c ();

  vga_sincronismo #(.DIV_PIXEL(2), .H_ATIVO(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ATIVO(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB))
    dut_a (.clk(clk), .rst(rst), .vga(if_a));
  vga_sincronismo #(.DIV_PIXEL(1), .H_ATIVO(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ATIVO(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB))
    dut_b (.clk(clk), .rst(rst), .vga(if_b));
  vga_sincronismo #(.DIV_PIXEL(3), .H_ATIVO(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ATIVO(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB))
    dut_c (.clk(clk), .rst(rst), .vga(if_c));

  int     total = 0;
  int     bad   = 0;
  int     k     = 0;
  bit     armed = 1'b0;
  longint ciclo = 0;
  longint ult_fim [3];
  bit     val_fim [3];

  typedef struct packed {
    int pix; int col; int lin; int area; int hs; int vs; int fim;
  } esperado_t;

  task automatic verificar(input string tag, input logic [31:0] got, input int exp);
    total++;
    if (got !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // k = clock edges since the last edge that sampled rst high.
  function automatic esperado_t modelo(input int kk, input int dv);
    esperado_t e;
    int n, idx;
    e = '{default: 0};
    e.hs = 1;
    e.vs = 1;
    if (kk == 0) return e;
    e.pix = (kk % dv == dv - 1) ? 1 : 0;
    n   = (dv == 1) ? kk - 1 : kk / dv;
    idx = n % (HT * VT);
    e.col = idx % HT;
    e.lin = idx / HT;
    if (n > 0) begin
      e.area = (e.col < HA && e.lin < VA) ? 1 : 0;
      e.hs   = (e.col >= HA + HF && e.col < HA + HF + HS) ? 0 : 1;
      e.vs   = (e.lin >= VA + VF && e.lin < VA + VF + VS) ? 0 : 1;
      e.fim  = (idx == 0 && kk >= 2 && kk % dv == 0) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic comparar(input string nome, input int id, input logic pix,
                          input logic [9:0] col, input logic [9:0] lin,
                          input logic area, input logic hs, input logic vs,
                          input logic fim);
    esperado_t e;
    e = modelo(k, DIVS[id]);
    verificar($sformatf("%s k=%0d pix_en", nome, k), 32'(pix), e.pix);
    verificar($sformatf("%s k=%0d coluna", nome, k), 32'(col), e.col);
    verificar($sformatf("%s k=%0d linha", nome, k), 32'(lin), e.lin);
    verificar($sformatf("%s k=%0d areaAtiva", nome, k), 32'(area), e.area);
    verificar($sformatf("%s k=%0d hsync", nome, k), 32'(hs), e.hs);
    verificar($sformatf("%s k=%0d vsync", nome, k), 32'(vs), e.vs);
    verificar($sformatf("%s k=%0d fim_quadro", nome, k), 32'(fim), e.fim);
    if (fim === 1'b1) begin
      if (val_fim[id])
        verificar($sformatf("%s frame period", nome), 32'(ciclo - ult_fim[id]),
                  HT * VT * DIVS[id]);
      ult_fim[id] = ciclo;
      val_fim[id] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    ciclo = ciclo + 1;
    if (rst) begin
      k     = 0;
      armed = 1'b1;
      for (int i = 0; i < 3; i++) val_fim[i] = 1'b0;
    end else begin
      k = k + 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      comparar("A", 0, if_a.pix_en, if_a.coluna, if_a.linha, if_a.areaAtiva,
               if_a.hsync, if_a.vsync, if_a.fim_quadro);
      comparar("B", 1, if_b.pix_en, if_b.coluna, if_b.linha, if_b.areaAtiva,
               if_b.hsync, if_b.vsync, if_b.fim_quadro);
      comparar("C", 2, if_c.pix_en, if_c.coluna, if_c.linha, if_c.areaAtiva,
               if_c.hsync, if_c.vsync, if_c.fim_quadro);
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) val_fim[i] = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    verificar("A first tick coluna", 32'(if_a.coluna), 1);
    verificar("A first tick areaAtiva", 32'(if_a.areaAtiva), 1);
    repeat (1500) @(negedge clk);

    // line 5, column 10 of DUT A with its divider on the odd phase
    for (int i = 0; i < 1000 && (k % (HT * VT * 2)) != 251; i++) @(negedge clk);
    verificar("A mid reset linha", 32'(if_a.linha), 5);
    verificar("A mid reset coluna", 32'(if_a.coluna), 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (1000) @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(1, 700)) @(negedge clk);
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b0;
    end
    repeat (1600) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
